axi_rs_arb: RTL and testbench
=============================

Name: axi_rs_arb

Overview:
- Round-robin, packet-locking arbiter that shares one valid/ready register-slice channel between 2**IW requesters.
- Sits in front of the AXI register slice on shared write-data or read-response paths.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted.
- Drives the shared channel through a forward output register tagged with the winner's index.

Parameters:
- DW, 64, payload width per requester and at the output.
- IW, 2, requester index width; N = 2**IW requesters (localparam, default 4).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_data  input  N*DW  requester payloads; requester i occupies bits [i*DW +: DW].
- m_valid  input  N  per-requester valid.
- m_last  input  N  per-requester last-beat flag.
- m_ready  output  N  per-requester ready, combinational; at most one bit set.
- s_data  output  DW  registered payload to the shared channel.
- s_valid  output  1  registered valid.
- s_last  output  1  registered last flag.
- s_id  output  IW  registered index of the source requester.
- s_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): s_valid=0, s_data=0, s_last=0, s_id=0, state=IDLE, grant=0, rr_ptr=0; m_ready=0 while rst_n=0.
- State IDLE:
  - m_ready all 0.
  - If any m_valid bit is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N.
  - grant <= winner; state <= LOCKED next edge.
  - If no request is present, stay IDLE.
- State LOCKED:
  - m_ready[grant] = !s_valid || s_ready; all other m_ready bits are 0.
  - An input beat is accepted when m_valid[grant] && m_ready[grant].
  - On accept: s_data <= m_data[grant], s_last <= m_last[grant], s_id <= grant, s_valid <= 1.
  - If the accepted beat has m_last=1: state <= IDLE, rr_ptr <= grant+1 (wraps modulo N, IW-bit natural wrap).
  - Accept without last: stay LOCKED.
- Output register:
  - When s_valid && s_ready and no new beat is accepted the same cycle, s_valid <= 0.
  - Simultaneous output drain and input accept: register reloads with the new beat and s_valid stays 1, giving full throughput inside a packet.
  - With s_ready=0 and s_valid=1, s_data, s_last and s_id are held stable.
- Latency:
  - Request seen in IDLE at cycle 0; m_ready asserted cycle 1; s_valid earliest cycle 2.
  - Exactly one idle arbitration cycle between packets; the output register may still drain during it.
- Non-granted requesters: their valid is ignored; grant is not preempted mid-packet regardless of other requests.
- Granted requester deasserts m_valid mid-packet: grant is held and the arbiter waits indefinitely; no timeout.
- Single-beat packets (m_last=1 on first beat): LOCKED lasts until that one beat is accepted.
- m_last is sampled only when its beat is accepted.
- Reset mid-packet: all state cleared immediately. The partial packet is abandoned. The registered beat is discarded (s_valid=0).
- No combinational path from m_valid to m_ready; m_ready depends only on state, grant, s_valid and s_ready.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles with m_valid=4'b1111 -> s_valid=0, m_ready=0, s_id=0 throughout; first grant after release goes to requester 0.
- Round-robin fairness: all 4 requesters continuously send 1-beat packets (m_last=1), s_ready=1 -> s_id sequence is 0,1,2,3,0,1..., with one beat every 2 cycles.
- Packet lock: requester 2 sends a 4-beat packet (data 0xA0..0xA3, last on 0xA3) while requester 1 requests -> output is 0xA0..0xA3 with s_id=2 back-to-back, then requester 1 is granted; m_ready[1]=0 throughout requester 2's packet.
- Backpressure: during a 3-beat packet, drive s_ready=0 for 5 cycles after the first beat -> s_data, s_last, s_id stable; m_ready[grant]=0 while s_valid=1 && s_ready=0; no beat lost or duplicated.
- Wrap-around pointer: requester 3 finishes a packet while requesters 0 and 2 request -> rr_ptr=0 and requester 0 wins next.
- Reset mid-packet: assert rst_n=0 after the 2nd beat of a 4-beat packet -> s_valid drops asynchronously; after release, state is IDLE and rr_ptr=0.

Source files
------------

// File: rtl/axi_rs_arb.sv
// axi_rs_arb: round-robin, packet-locking arbiter that shares one registered valid/ready channel.
// Latency: a request seen in IDLE raises m_ready one cycle later, and s_valid follows one cycle after that; there is one idle arbitration cycle between packets.
// Backpressure: m_ready[grant] is set when the output register is empty or draining, and every other requester sees m_ready=0.
module axi_rs_arb #(
  parameter int DW = 64,
  parameter int IW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(2**IW)*DW-1:0]  m_data,
  input  logic [(2**IW)-1:0]     m_valid,
  input  logic [(2**IW)-1:0]     m_last,
  output logic [(2**IW)-1:0]     m_ready,
  output logic [DW-1:0]          s_data,
  output logic                   s_valid,
  output logic                   s_last,
  output logic [IW-1:0]          s_id,
  input  logic                   s_ready
);

  localparam int N = 2 ** IW;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;

  logic [IW-1:0] winner;
  logic [IW-1:0] idx;
  logic          found;
  logic          out_free;
  logic          accept;
  logic [DW-1:0] sel_data;

  // The output register can take a beat when it is empty or draining this cycle.
  assign out_free = !s_valid || s_ready;
  assign accept   = (state == LOCKED) && m_valid[grant] && out_free;
  assign sel_data = m_data[grant*DW +: DW];

  // Pick the first requesting index, scanning from rr_ptr upward with natural IW-bit wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_ptr + IW'(i);
      if (!found && m_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Only the locked requester can see ready; m_valid is not involved, so there is no valid->ready path.
  always_comb begin
    m_ready = '0;
    if (state == LOCKED) begin
      m_ready[grant] = out_free;
    end
  end

  // Arbitration state, round-robin pointer, and the forward output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_last  <= 1'b0;
      s_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= winner;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // The grant holds until the last beat is taken; the pointer then moves past the finished requester.
          if (accept && m_last[grant]) begin
            state  <= IDLE;
            rr_ptr <= grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A new beat reloads the register even while the old one drains, which keeps full throughput inside a packet.
      if (accept) begin
        s_data  <= sel_data;
        s_last  <= m_last[grant];
        s_id    <= grant;
        s_valid <= 1'b1;
      end else if (s_ready) begin
        s_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_rs_arb.sv
module tb_axi_rs_arb;

  localparam int DW = 64;
  localparam int IW = 2;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] m_data = '0;
  logic [N-1:0]    m_valid = '0;
  logic [N-1:0]    m_last = '0;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_last;
  logic [IW-1:0]   s_id;
  logic            s_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] dat;
    logic        last;
    int          cyc;
  } beat_t;
  beat_t obs[$];

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       rdy;
    logic [3:0] exp_mrdy;
    logic       exp_sv;
    logic [1:0] exp_id;
  } vec_t;
  vec_t vec[11];

  axi_rs_arb #(.DW(DW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_id(s_id), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Record every beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && s_valid && s_ready) obs.push_back('{s_id, s_data, s_last, cyc_cnt});
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_dat(input int i, input logic [63:0] v);
    m_data[i*DW +: DW] = v;
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    m_valid = '0;
    m_last  = '0;
    s_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [63:0] held_dat;
  logic [1:0]  held_id;
  logic        held_last;
  int          k;
  int          stall;
  logic        seen_r1;

  initial begin
    // Round-robin table: every requester sends single-beat packets continuously.
    vec[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    vec[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vec[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0};
    vec[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0};
    vec[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1};
    vec[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 2'd1};
    vec[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2};
    vec[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, 2'd2};
    vec[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3};
    vec[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd3};
    vec[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0};

    for (int i = 0; i < N; i++) set_dat(i, 64'(8'hD0 + i));

    // Reset hold with every requester asking.
    for (int c = 0; c < 3; c++) begin
      next();
      m_valid = 4'b1111;
      m_last  = 4'b1111;
      #1;
      chk("rst_s_valid", 64'(s_valid), 64'(0));
      chk("rst_m_ready", 64'(m_ready), 64'(0));
      chk("rst_s_id", 64'(s_id), 64'(0));
    end

    for (int i = 0; i < 11; i++) begin
      next();
      if (i == 0) rst_n = 1'b1;
      m_valid = vec[i].vld;
      m_last  = vec[i].lst;
      s_ready = vec[i].rdy;
      #1;
      chk($sformatf("rr_m_ready[%0d]", i), 64'(m_ready), 64'(vec[i].exp_mrdy));
      chk($sformatf("rr_s_valid[%0d]", i), 64'(s_valid), 64'(vec[i].exp_sv));
      chk($sformatf("rr_s_id[%0d]", i), 64'(s_id), 64'(vec[i].exp_id));
      if (vec[i].exp_sv) begin
        chk($sformatf("rr_s_data[%0d]", i), s_data, 64'(8'hD0) + 64'(vec[i].exp_id));
        chk($sformatf("rr_s_last[%0d]", i), 64'(s_last), 64'(1));
      end
    end

    // Packet lock: requester 2 sends four beats while requester 1 waits.
    reset_dut();
    next();
    m_valid = 4'b0100;
    m_last  = 4'b0000;
    set_dat(2, 64'hA0);
    set_dat(1, 64'hB1);
    obs.delete();
    k = 0;
    seen_r1 = 1'b0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      next();
      m_valid = 4'b0110;
      set_dat(2, 64'(8'hA0 + k));
      m_last = (k == 3) ? 4'b0100 : 4'b0000;
      #1;
      if (m_ready[1]) seen_r1 = 1'b1;
      if (m_ready[2]) k++;
    end
    chk("lock_beats_taken", 64'(k), 64'(4));
    chk("lock_r1_never_ready", 64'(seen_r1), 64'(0));
    next();
    m_valid = 4'b0010;
    m_last  = 4'b0010;
    #1;
    chk("lock_arb_cycle_mrdy", 64'(m_ready), 64'(0));
    next();
    #1;
    chk("lock_r1_granted", 64'(m_ready), 64'(4'b0010));
    next();
    m_valid = '0;
    m_last  = '0;
    repeat (3) next();
    chk("lock_obs_count", 64'(obs.size()), 64'(5));
    if (obs.size() == 5) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("lock_id[%0d]", j), 64'(obs[j].id), 64'(2));
        chk($sformatf("lock_dat[%0d]", j), obs[j].dat, 64'(8'hA0 + j));
        chk($sformatf("lock_last[%0d]", j), 64'(obs[j].last), 64'(j == 3));
        if (j > 0) chk($sformatf("lock_b2b[%0d]", j), 64'(obs[j].cyc - obs[j-1].cyc), 64'(1));
      end
      chk("lock_next_id", 64'(obs[4].id), 64'(1));
      chk("lock_next_dat", obs[4].dat, 64'hB1);
    end

    // Backpressure: 3-beat packet, output stalled for 5 cycles after the first beat.
    reset_dut();
    next();
    m_valid = 4'b0001;
    m_last  = 4'b0000;
    set_dat(0, 64'hC0);
    obs.delete();
    k = 0;
    stall = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      next();
      set_dat(0, 64'(8'hC0 + k));
      m_last = (k == 2) ? 4'b0001 : 4'b0000;
      if (s_valid && stall < 5) begin
        s_ready = 1'b0;
        stall++;
      end else begin
        s_ready = 1'b1;
      end
      #1;
      if (!s_ready) begin
        chk("bp_m_ready_low", 64'(m_ready), 64'(0));
        if (stall == 1) begin
          held_dat  = s_data;
          held_id   = s_id;
          held_last = s_last;
        end else begin
          chk("bp_dat_stable", s_data, held_dat);
          chk("bp_id_stable", 64'(s_id), 64'(held_id));
          chk("bp_last_stable", 64'(s_last), 64'(held_last));
        end
      end
      if (m_ready[0]) k++;
    end
    next();
    m_valid = '0;
    m_last  = '0;
    s_ready = 1'b1;
    repeat (3) next();
    chk("bp_stalls", 64'(stall), 64'(5));
    chk("bp_obs_count", 64'(obs.size()), 64'(3));
    if (obs.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("bp_dat[%0d]", j), obs[j].dat, 64'(8'hC0 + j));
        chk($sformatf("bp_id[%0d]", j), 64'(obs[j].id), 64'(0));
        chk($sformatf("bp_last[%0d]", j), 64'(obs[j].last), 64'(j == 2));
      end
    end

    // Pointer wrap: requester 3 finishes while requesters 0 and 2 are waiting.
    reset_dut();
    next();
    m_valid = 4'b1000;
    m_last  = 4'b1111;
    set_dat(3, 64'hE3);
    next();
    m_valid = 4'b1101;
    #1;
    chk("wrap_r3_ready", 64'(m_ready), 64'(4'b1000));
    next();
    m_valid = 4'b0101;
    #1;
    chk("wrap_arb_mrdy", 64'(m_ready), 64'(0));
    chk("wrap_out_id", 64'(s_id), 64'(3));
    chk("wrap_out_dat", s_data, 64'hE3);
    next();
    #1;
    chk("wrap_r0_wins", 64'(m_ready), 64'(4'b0001));
    next();
    m_valid = '0;

    // Reset mid-packet: first move the pointer to 3, then break a packet from requester 3.
    reset_dut();
    next();
    m_valid = 4'b0100;
    m_last  = 4'b0100;
    next();
    next();
    m_valid = 4'b1000;
    m_last  = 4'b0000;
    set_dat(3, 64'hF0);
    next();
    set_dat(3, 64'hF0);
    next();
    set_dat(3, 64'hF1);
    next();
    set_dat(3, 64'hF2);
    #1;
    chk("mid_pre_valid", 64'(s_valid), 64'(1));
    chk("mid_pre_dat", s_data, 64'hF1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 64'(s_valid), 64'(0));
    chk("mid_async_mrdy", 64'(m_ready), 64'(0));
    chk("mid_async_id", 64'(s_id), 64'(0));
    next();
    rst_n   = 1'b1;
    m_valid = 4'b1100;
    m_last  = 4'b1100;
    #1;
    chk("mid_idle_mrdy", 64'(m_ready), 64'(0));
    chk("mid_idle_valid", 64'(s_valid), 64'(0));
    next();
    #1;
    chk("mid_ptr_zero_r2_wins", 64'(m_ready), 64'(4'b0100));
    next();
    m_valid = '0;
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
